// File: rtl/miner_pkg.sv
// Shared state encoding, default widths and nonce field position for the mining scheduler.
package miner_pkg;

    localparam int DEF_HDR_W   = 640;
    localparam int DEF_NONCE_W = 32;
    localparam int DEF_HASH_W  = 256;

    // The nonce sits in the low word of the block header.
    localparam int NONCE_LSB = 0;
    localparam int NONCE_MSB = 31;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        REPORT
    } state_t;

endpackage

// File: rtl/mine_watchdog.sv
// Watchdog for the wait-on-core phase: cleared per request, counts while enabled,
// and flags the terminal count one cycle before the limit is reached.
module mine_watchdog
    import miner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    assign tc = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter: clear wins over enable; holds once terminal count is reached.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mine_scheduler.sv
// Mining job sequencer: captures a header/target, walks nonces through the hash
// core one request at a time, and reports a single result record.
module mine_scheduler
    import miner_pkg::*;
#(
    parameter int HDR_W          = DEF_HDR_W,
    parameter int NONCE_W        = DEF_NONCE_W,
    parameter int HASH_W         = DEF_HASH_W,
    parameter int MAX_ATTEMPTS   = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hdr_valid,
    input  logic [HDR_W-1:0]   hdr_data,
    input  logic [HASH_W-1:0]  target,
    input  logic               abort,
    output logic               core_start,
    output logic [HDR_W-1:0]   core_header,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_found,
    output logic               res_timeout,
    output logic [NONCE_W-1:0] res_nonce,
    output logic [31:0]        attempts,
    output logic               busy
);

    state_t state, state_nx;

    logic [HDR_W-1:NONCE_MSB+1] hdr_hi;
    logic [NONCE_W-1:0]         base;
    logic [NONCE_W-1:0]         nonce;
    logic [NONCE_W-1:0]         nonce_inc;
    logic [HASH_W-1:0]          tgt;
    logic [HASH_W-1:0]          hash;
    logic                       wd_tc;
    logic                       hit;
    logic                       wrapped;
    logic                       budget_hit;

    assign nonce_inc  = nonce + NONCE_W'(1);
    assign hit        = hash <= tgt;
    // Walking the whole range ends when the next nonce would be the base again.
    assign wrapped    = nonce_inc == base;
    assign budget_hit = (MAX_ATTEMPTS != 0) && (attempts + 32'd1 == 32'(MAX_ATTEMPTS));

    mine_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock(clock),
        .reset(reset),
        .clr  (state == ISSUE),
        .en   (state == WAIT),
        .tc   (wd_tc)
    );

    // Next-state selection; abort only cancels while a job is searching.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hdr_valid) state_nx = ISSUE;
            ISSUE:   state_nx = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort)          state_nx = IDLE;
                else if (core_done) state_nx = CHECK;
                else if (wd_tc)     state_nx = REPORT;
            end
            CHECK: begin
                if (abort)                          state_nx = IDLE;
                else if (hit || wrapped || budget_hit) state_nx = REPORT;
                else                                state_nx = ISSUE;
            end
            REPORT:  if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, job context and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hdr_hi      <= '0;
            base        <= '0;
            nonce       <= '0;
            tgt         <= '0;
            hash        <= '0;
            core_start  <= 1'b0;
            core_header <= '0;
            res_valid   <= 1'b0;
            res_found   <= 1'b0;
            res_timeout <= 1'b0;
            res_nonce   <= '0;
            attempts    <= '0;
            busy        <= 1'b0;
        end else begin
            state      <= state_nx;
            core_start <= (state == ISSUE) && !abort;
            busy       <= state_nx != IDLE;
            res_valid  <= state_nx == REPORT;
            case (state)
                IDLE: begin
                    if (hdr_valid) begin
                        hdr_hi      <= hdr_data[HDR_W-1:NONCE_MSB+1];
                        base        <= hdr_data[NONCE_MSB:NONCE_LSB];
                        nonce       <= hdr_data[NONCE_MSB:NONCE_LSB];
                        tgt         <= target;
                        attempts    <= '0;
                        res_found   <= 1'b0;
                        res_timeout <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!abort) core_header <= {hdr_hi, nonce};
                end
                WAIT: begin
                    // A result arriving on the expiry cycle still counts.
                    if (!abort) begin
                        if (core_done) begin
                            hash <= core_hash;
                        end else if (wd_tc) begin
                            res_timeout <= 1'b1;
                            res_nonce   <= nonce;
                        end
                    end
                end
                CHECK: begin
                    if (!abort) begin
                        attempts <= attempts + 32'd1;
                        if (hit) begin
                            res_found <= 1'b1;
                            res_nonce <= nonce;
                        end else if (wrapped || budget_hit) begin
                            res_found <= 1'b0;
                            res_nonce <= nonce;
                        end else begin
                            nonce <= nonce_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mine_scheduler.sv
// Bench for mine_scheduler: two instances (full-range/long watchdog and
// 4-attempt/16-cycle watchdog), a scripted hash core, and a job-level model.
module tb_mine_scheduler;

    localparam int TMO0 = 4096;
    localparam int TMO1 = 16;
    localparam int MAX1 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         hv [2];
    logic [639:0] hd [2];
    logic [255:0] tg [2];
    logic         ab [2];
    logic         cd [2];
    logic [255:0] ch [2];
    logic         rr [2];
    logic         cs [2];
    logic [639:0] chdr [2];
    logic         rv [2];
    logic         rf [2];
    logic         rt [2];
    logic [31:0]  rn [2];
    logic [31:0]  att [2];
    logic         bz [2];

    mine_scheduler u0 (
        .clock(clk), .reset(rst), .hdr_valid(hv[0]), .hdr_data(hd[0]), .target(tg[0]),
        .abort(ab[0]), .core_start(cs[0]), .core_header(chdr[0]), .core_done(cd[0]),
        .core_hash(ch[0]), .res_valid(rv[0]), .res_ready(rr[0]), .res_found(rf[0]),
        .res_timeout(rt[0]), .res_nonce(rn[0]), .attempts(att[0]), .busy(bz[0])
    );

    mine_scheduler #(.MAX_ATTEMPTS(MAX1), .TIMEOUT_CYCLES(TMO1)) u1 (
        .clock(clk), .reset(rst), .hdr_valid(hv[1]), .hdr_data(hd[1]), .target(tg[1]),
        .abort(ab[1]), .core_start(cs[1]), .core_header(chdr[1]), .core_done(cd[1]),
        .core_hash(ch[1]), .res_valid(rv[1]), .res_ready(rr[1]), .res_found(rf[1]),
        .res_timeout(rt[1]), .res_nonce(rn[1]), .attempts(att[1]), .busy(bz[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- scripted hash core ----------------
    int           cnt [2]      = '{0, 0};
    int           resp_n [2]   = '{0, 0};
    int           job_base [2] = '{0, 0};
    int           win [2]      = '{-1, -1};
    logic [255:0] win_hash [2];
    bit           en [2]       = '{1'b1, 1'b1};
    int           lat [2]      = '{20, 5};
    int           inj_req [2]  = '{0, 0};
    int           inj_ack [2]  = '{0, 0};

    initial begin
        for (int d = 0; d < 2; d++) begin
            cd[d] = 1'b0;
            ch[d] = '0;
        end
        forever begin
            @(negedge clk or posedge rst);
            for (int d = 0; d < 2; d++) begin
                cd[d] = 1'b0;
                if (rst) begin
                    cnt[d] = 0;
                end else begin
                    if (inj_req[d] != inj_ack[d]) begin
                        cd[d] = 1'b1;
                        ch[d] = '0;
                        inj_ack[d] = inj_req[d];
                    end else if (cnt[d] > 0) begin
                        cnt[d]--;
                        if (cnt[d] == 0) begin
                            cd[d] = 1'b1;
                            ch[d] = (resp_n[d] - job_base[d] == win[d]) ? win_hash[d] : '1;
                            resp_n[d]++;
                        end
                    end
                    if (cs[d] && en[d]) cnt[d] = lat[d];
                end
            end
        end
    end

    // ---------------- job-level model ----------------
    // A job is a sequence of phases tracked as flags: a request is due, a
    // request is in flight (aged for the watchdog), a hash awaits judging,
    // or a record is on offer.
    bit           f_issue [2], f_fly [2], f_judge [2], f_rep [2];
    int           age [2];
    logic [607:0] m_hi [2];
    logic [31:0]  m_base [2], m_non [2];
    logic [255:0] m_tgt [2], m_hash [2];
    logic         e_cs [2], e_rv [2], e_rf [2], e_rt [2], e_bz [2];
    logic [639:0] e_hdr [2];
    logic [31:0]  e_rn [2], e_att [2];

    function automatic int tmo(input int d);
        return (d == 0) ? TMO0 : TMO1;
    endfunction

    function automatic int maxa(input int d);
        return (d == 0) ? 0 : MAX1;
    endfunction

    task automatic model_clear(input int d);
        f_issue[d] = 0; f_fly[d] = 0; f_judge[d] = 0; f_rep[d] = 0; age[d] = 0;
        m_hi[d] = '0; m_base[d] = '0; m_non[d] = '0; m_tgt[d] = '0; m_hash[d] = '0;
        e_cs[d] = 0; e_rv[d] = 0; e_rf[d] = 0; e_rt[d] = 0; e_bz[d] = 0;
        e_hdr[d] = '0; e_rn[d] = '0; e_att[d] = '0;
    endtask

    task automatic model_step(input int d);
        logic [31:0] nx;
        e_cs[d] = 0;
        if (f_rep[d]) begin
            if (rr[d]) f_rep[d] = 0;
        end else if ((f_issue[d] || f_fly[d] || f_judge[d]) && ab[d]) begin
            f_issue[d] = 0; f_fly[d] = 0; f_judge[d] = 0;
        end else if (f_issue[d]) begin
            e_cs[d]    = 1;
            e_hdr[d]   = {m_hi[d], m_non[d]};
            f_issue[d] = 0;
            f_fly[d]   = 1;
            age[d]     = 0;
        end else if (f_fly[d]) begin
            if (cd[d]) begin
                m_hash[d] = ch[d];
                f_fly[d] = 0;
                f_judge[d] = 1;
            end else begin
                age[d]++;
                if (age[d] == tmo(d)) begin
                    f_fly[d] = 0;
                    e_rt[d] = 1;
                    e_rn[d] = m_non[d];
                    f_rep[d] = 1;
                end
            end
        end else if (f_judge[d]) begin
            f_judge[d] = 0;
            e_att[d] = e_att[d] + 1;
            nx = m_non[d] + 32'd1;
            if (m_hash[d] <= m_tgt[d]) begin
                e_rf[d] = 1; e_rn[d] = m_non[d]; f_rep[d] = 1;
            end else if (nx == m_base[d] || (maxa(d) != 0 && e_att[d] == 32'(maxa(d)))) begin
                e_rn[d] = m_non[d]; f_rep[d] = 1;
            end else begin
                m_non[d] = nx; f_issue[d] = 1;
            end
        end else if (hv[d]) begin
            m_hi[d] = hd[d][639:32];
            m_base[d] = hd[d][31:0];
            m_non[d] = hd[d][31:0];
            m_tgt[d] = tg[d];
            e_att[d] = '0; e_rf[d] = 0; e_rt[d] = 0;
            f_issue[d] = 1;
        end
        e_rv[d] = f_rep[d];
        e_bz[d] = f_issue[d] | f_fly[d] | f_judge[d] | f_rep[d];
    endtask

    initial begin
        for (int d = 0; d < 2; d++) model_clear(d);
        forever begin
            @(posedge clk or posedge rst);
            for (int d = 0; d < 2; d++) begin
                if (rst) model_clear(d);
                else     model_step(d);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int cs_cnt [2] = '{0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d busy", d), bz[d], e_bz[d]);
                chk($sformatf("d%0d core_start", d), cs[d], e_cs[d]);
                chk($sformatf("d%0d core_header", d), chdr[d], e_hdr[d]);
                chk($sformatf("d%0d res_valid", d), rv[d], e_rv[d]);
                chk($sformatf("d%0d res_found", d), rf[d], e_rf[d]);
                chk($sformatf("d%0d res_timeout", d), rt[d], e_rt[d]);
                chk($sformatf("d%0d res_nonce", d), rn[d], e_rn[d]);
                chk($sformatf("d%0d attempts", d), att[d], e_att[d]);
                if (cs[d] === 1'b1) cs_cnt[d]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_job(input int d, input logic [31:0] nonce0, input logic [255:0] t);
        @(negedge clk);
        hv[d] = 1'b1;
        hd[d] = {{19{32'h13579bdf}}, nonce0};
        tg[d] = t;
        @(negedge clk);
        hv[d] = 1'b0;
    endtask

    task automatic wait_rv(input int d, input int bound);
        int n = 0;
        while (rv[d] !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("d%0d res_valid within bound", d), rv[d], 1'b1);
    endtask

    task automatic wait_cs(input int d, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cs[d] !== 1'b1 && n < bound);
        chk($sformatf("d%0d core_start within bound", d), cs[d], 1'b1);
    endtask

    task automatic release_res(input int d);
        @(negedge clk);
        rr[d] = 1'b1;
        @(negedge clk);
        rr[d] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] seen [$];
        logic [31:0] exp_seq [4];
        logic        snap_f, snap_t;
        logic [31:0] snap_n, snap_a;
        int          st, n;

        exp_seq = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        for (int d = 0; d < 2; d++) begin
            hv[d] = 0; hd[d] = '0; tg[d] = '0; ab[d] = 0; rr[d] = 0; win_hash[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset busy", bz[d], 1'b0);
            chk("reset core_header", chdr[d], '0);
            chk("reset res_valid", rv[d], 1'b0);
            chk("reset attempts", att[d], 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Success on the second nonce, then backpressure on the record.
        job_base[0] = resp_n[0];
        win[0] = 1;
        win_hash[0] = {64'h0000000000001234, 192'h0};
        st = cs_cnt[0];
        start_job(0, 32'h42a14694, {32'h0, {224{1'b1}}});
        wait_rv(0, 300);
        chk("t1 res_found", rf[0], 1'b1);
        chk("t1 res_timeout", rt[0], 1'b0);
        chk("t1 res_nonce", rn[0], 32'h42a14695);
        chk("t1 attempts", att[0], 32'd2);
        chk("t1 core_start count", 32'(cs_cnt[0] - st), 32'd2);
        snap_f = rf[0]; snap_t = rt[0]; snap_n = rn[0]; snap_a = att[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hv[0] = (i == 3);
            chk("t4 res_valid held", rv[0], 1'b1);
            chk("t4 busy held", bz[0], 1'b1);
            chk("t4 record stable", {snap_f, snap_t, snap_n, snap_a}, {rf[0], rt[0], rn[0], att[0]});
        end
        @(negedge clk);
        hv[0] = 0;
        rr[0] = 1'b1;
        @(negedge clk);
        rr[0] = 1'b0;
        chk("t4 res_valid dropped", rv[0], 1'b0);
        chk("t4 idle after transfer", bz[0], 1'b0);
        repeat (5) @(negedge clk);
        chk("t4 ignored hdr_valid", 32'(cs_cnt[0] - st), 32'd2);

        // Abort while waiting on the fourth request.
        job_base[0] = resp_n[0];
        win[0] = -1;
        st = cs_cnt[0];
        start_job(0, 32'h00000010, '0);
        n = 0;
        while (cs_cnt[0] - st < 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t5 reached attempt 4", 32'(cs_cnt[0] - st), 32'd4);
        repeat (2) @(negedge clk);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("t5 idle after abort", bz[0], 1'b0);
        chk("t5 attempts kept", att[0], 32'd3);
        repeat (40) begin
            @(negedge clk);
            chk("t5 no result", rv[0], 1'b0);
        end
        chk("t5 no further start", 32'(cs_cnt[0] - st), 32'd4);
        job_base[0] = resp_n[0];
        win[0] = 0;
        win_hash[0] = '0;
        start_job(0, 32'h00000077, '0);
        chk("t5 clean job attempts", att[0], 32'd0);
        wait_rv(0, 100);
        chk("t5 clean job found", rf[0], 1'b1);
        chk("t5 clean job nonce", rn[0], 32'h00000077);
        chk("t5 clean job attempts done", att[0], 32'd1);
        release_res(0);

        // Reset between clock edges while waiting on the core.
        job_base[0] = resp_n[0];
        win[0] = 0;
        start_job(0, 32'h00000500, '0);
        wait_cs(0, 10);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6 busy", bz[0], 1'b0);
        chk("t6 core_start", cs[0], 1'b0);
        chk("t6 core_header", chdr[0], '0);
        chk("t6 res_valid", rv[0], 1'b0);
        chk("t6 res_nonce", rn[0], 32'd0);
        chk("t6 attempts", att[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        job_base[0] = resp_n[0];
        start_job(0, 32'h00000600, '0);
        wait_rv(0, 100);
        chk("t6 after reset found", rf[0], 1'b1);
        chk("t6 after reset nonce", rn[0], 32'h00000600);
        release_res(0);

        // Attempt budget across the 32-bit wrap.
        job_base[1] = resp_n[1];
        win[1] = -1;
        start_job(1, 32'hFFFFFFFE, '0);
        n = 0;
        while (rv[1] !== 1'b1 && n < 200) begin
            @(negedge clk);
            if (cs[1] === 1'b1) seen.push_back(chdr[1][31:0]);
            n++;
        end
        chk("t2 request count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) chk($sformatf("t2 nonce %0d", i), seen[i], exp_seq[i]);
        chk("t2 res_found", rf[1], 1'b0);
        chk("t2 res_nonce", rn[1], 32'h00000001);
        chk("t2 attempts", att[1], 32'd4);
        release_res(1);

        // Watchdog expiry with a silent core.
        en[1] = 1'b0;
        start_job(1, 32'h00000100, '1);
        wait_rv(1, 100);
        chk("t3 res_timeout", rt[1], 1'b1);
        chk("t3 res_found", rf[1], 1'b0);
        chk("t3 res_nonce", rn[1], 32'h00000100);
        chk("t3 attempts", att[1], 32'd0);
        release_res(1);

        // core_done on the expiry cycle takes the check path.
        start_job(1, 32'h00000200, '1);
        wait_cs(1, 10);
        repeat (15) @(posedge clk);
        #1 inj_req[1]++;
        wait_rv(1, 50);
        chk("t3b res_timeout", rt[1], 1'b0);
        chk("t3b res_found", rf[1], 1'b1);
        chk("t3b res_nonce", rn[1], 32'h00000200);
        chk("t3b attempts", att[1], 32'd1);
        release_res(1);
        en[1] = 1'b1;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mine_scheduler.md
Name: mine_scheduler

Overview:
- Sequences the hash-core datapath for one mining job.
- Captures a 640-bit block header and a 256-bit target from the UART side.
- Issues one hash request per nonce to the miner core and compares each returned hash against the target.
- Stops on success, nonce-budget exhaustion or core timeout, then hands a single result record to the serial sender via a valid/ready handshake.

Parameters:
- HDR_W, 640: block header width; the nonce occupies bits [31:0].
- NONCE_W, 32: nonce width.
- HASH_W, 256: hash and target width.
- MAX_ATTEMPTS, 0: attempt budget per job; 0 means the full 2^32 range (stop on wrap back to the base nonce).
- TIMEOUT_CYCLES, 4096: watchdog limit while waiting on core_done.

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high; clears all state
- hdr_valid  in  1  one-cycle pulse; new job present on hdr_data/target
- hdr_data  in  HDR_W  header; [31:0] is the base nonce
- target  in  HASH_W  success threshold, unsigned
- abort  in  1  cancel the current job
- core_start  out  1  one-cycle request to the hash core
- core_header  out  HDR_W  {header[639:32], current nonce}; held stable from core_start until the next core_start
- core_done  in  1  one-cycle pulse; core_hash is valid
- core_hash  in  HASH_W  hash result, compared as an unsigned integer
- res_valid  out  1  result record available
- res_ready  in  1  sender accepts the record
- res_found  out  1  hash <= target was met
- res_timeout  out  1  watchdog expired
- res_nonce  out  NONCE_W  last nonce tried (the winning nonce if found)
- attempts  out  32  hashes completed in the current or last job
- busy  out  1  state != IDLE

Behaviour:

Clock and reset:
- Reset is asynchronous, active-high.
- State goes to IDLE. All outputs are 0, including core_header, attempts and the res_* fields.
- All outputs are registered.

States: IDLE, ISSUE, WAIT, CHECK, REPORT.

- IDLE:
  - On hdr_valid, capture header[639:32], base=hdr_data[31:0], nonce=base, target.
  - Clear attempts, res_found and res_timeout. Go to ISSUE.
  - hdr_valid in any other state is ignored.
- ISSUE:
  - Drive core_start=1 for exactly one cycle; update core_header with the current nonce.
  - Clear the watchdog; go to WAIT.
  - First core_start appears 2 cycles after the hdr_valid edge.
- WAIT:
  - On core_done, latch core_hash and go to CHECK.
  - Else, when the watchdog reaches TIMEOUT_CYCLES-1, set res_timeout=1 and res_nonce=nonce, then go to REPORT.
  - If core_done coincides with expiry, core_done wins.
  - core_done outside WAIT is ignored.
- CHECK (one cycle): attempts+=1. Then, in priority order:
  - If hash <= target: res_found=1, res_nonce=nonce, go to REPORT.
  - Else if (nonce+1 mod 2^32)==base, or (MAX_ATTEMPTS!=0 and attempts+1==MAX_ATTEMPTS): res_found=0, res_nonce=nonce, go to REPORT.
  - Else nonce=nonce+1 (wraps 0xFFFFFFFF->0), go to ISSUE.
- REPORT:
  - Hold res_valid=1 with all res_* fields stable until res_ready=1.
  - On the cycle where res_valid & res_ready, go to IDLE; res_valid drops the next cycle.
- Steady-state throughput: ISSUE->WAIT->CHECK plus core latency; 3 overhead cycles per nonce.
- abort:
  - In ISSUE, WAIT or CHECK: go to IDLE next cycle, with no result and no further core_start.
  - A core_done arriving later is ignored. attempts keeps its value.
  - abort is ignored in IDLE and REPORT; an accepted result is never dropped.
- Reset mid-job (any state): immediately go to IDLE with all outputs 0. There is no pending handshake after reset.

Decomposition:
- Package miner_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, CHECK, REPORT);
  - the HDR_W, NONCE_W and HASH_W defaults;
  - the NONCE_LSB=0 and NONCE_MSB=31 field constants.
- One sub-module, mine_watchdog: a loadable counter with clear and enable inputs and a terminal-count pulse at TIMEOUT_CYCLES-1, reset asynchronously.

Test Plan:
1. Success on second nonce: base=0x42a14694, target=0x00000000FFFF...F. The core model returns hash=0xFF..F on the first request and 0x0000000000001234... on the second, 20 cycles after each core_start. Required: res_found=1, res_nonce=0x42a14695, attempts=2, exactly 2 core_start pulses.
2. Budget with wrap: MAX_ATTEMPTS=4, base=0xFFFFFFFE, core never meets target. Required: core_header[31:0] sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; res_found=0; res_nonce=0x00000001; attempts=4.
3. Timeout: TIMEOUT_CYCLES=16, core_done never asserted. Required: res_valid rises with res_timeout=1 and res_found=0. A core_done injected on exactly the expiry cycle instead yields the CHECK path (res_timeout=0).
4. Backpressure: hold res_ready=0 for 10 cycles after res_valid. Required: res_* stable throughout, busy=1, and a hdr_valid during REPORT is ignored. Releasing res_ready gives one transfer, then IDLE.
5. Abort: assert abort in WAIT after attempt 3. Required: IDLE next cycle, no res_valid, a late core_done ignored, and a following hdr_valid starts a clean job with attempts=0.
6. Reset mid-job: assert reset asynchronously in WAIT, between clock edges. Required: all outputs 0 before the next edge, and a new job runs normally after release.
